// File: rtl/plot_sink.sv
// plot_sink: receiving end of the pixel-plot interface.
// Buffers (x, y, colour) plot commands in a small FIFO and converts each one
// to a linear framebuffer address (y*160 + x). Commands are then written out
// through one output register under a mem_ready handshake. A full-screen
// hardware clear walks addresses 0..19199 once all pending plots have drained.
// Optional feature: define PLOT_SINK_CLIP_COUNT_EN to add the clip_count
// output, a saturating count of commands discarded by clipping.
module plot_sink #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  output logic        in_ready,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  input  logic        mem_ready,
  output logic        idle,
  output logic        overflow
`ifdef PLOT_SINK_CLIP_COUNT_EN
  ,
  output logic [15:0] clip_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [8:0]       WIDTH_C   = 9'(WIDTH);
  localparam logic [8:0]       HEIGHT_C  = 9'(HEIGHT);
  localparam logic [14:0]      LAST_ADDR = 15'd19199;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [17:0]      fifo_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_s;
  logic             mem_we_r, mem_we_s;
  logic [14:0]      mem_addr_r, mem_addr_s;
  logic [2:0]       mem_data_r, mem_data_s;
  logic [14:0]      clr_cnt_r, clr_cnt_s;
  logic [2:0]       clr_colour_r;
  logic             in_ready_r, in_ready_s;
  logic             idle_r, idle_s;
  logic             overflow_r;
  logic             in_range_s;
  logic             push_s, pop_s, drop_s;
  logic [14:0]      enq_addr_s;
  logic [17:0]      head_s;

  // A command is visible on screen only if it lies inside the grid.
  assign in_range_s = ({1'b0, x} < WIDTH_C) && ({1'b0, y} < HEIGHT_C);
  assign push_s     = plot && in_ready_r && in_range_s;
  assign drop_s     = plot && !in_ready_r && in_range_s;
  // The output register takes the FIFO head when empty or when its write completes.
  assign pop_s      = (count_r != CNT_ZERO) && (!mem_we_r || mem_ready) && (state_r != ST_CLEAR);
  // y*160 + x as two shifts; at most 19199, so 15 bits never wrap.
  assign enq_addr_s = ({7'd0, y} << 7) + ({7'd0, y} << 5) + {7'd0, x};
  assign head_s     = fifo_mem_r[rd_ptr_r];

  // Next FIFO occupancy from this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Next state plus next contents of the output register and clear counter.
  always_comb begin
    state_s    = state_r;
    mem_we_s   = mem_we_r;
    mem_addr_s = mem_addr_r;
    mem_data_s = mem_data_r;
    clr_cnt_s  = clr_cnt_r;
    if (pop_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = head_s[17:3];
      mem_data_s = head_s[2:0];
    end else if (mem_we_r && mem_ready && (state_r != ST_CLEAR)) begin
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = mem_we_r;
    end
    case (state_r)
      ST_RUN: begin
        if (clear_req) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Start the sweep only when no plot can still land after it.
        if ((count_r == CNT_ZERO) && !mem_we_r) begin
          state_s    = ST_CLEAR;
          mem_we_s   = 1'b1;
          mem_addr_s = 15'd0;
          mem_data_s = clr_colour_r;
          clr_cnt_s  = 15'd0;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (mem_ready) begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_s  = ST_RUN;
            mem_we_s = 1'b0;
          end else begin
            clr_cnt_s  = clr_cnt_r + 15'd1;
            mem_addr_s = clr_cnt_r + 15'd1;
          end
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: begin
        state_s  = ST_RUN;
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Status flags registered from next-cycle values so they match the spec'd combinational forms.
  always_comb begin
    in_ready_s = (state_s == ST_RUN) && (count_s < DEPTH_C);
    idle_s     = (state_s == ST_RUN) && (count_s == CNT_ZERO) && !mem_we_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO pointers, occupancy, output register, clear counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= CNT_ZERO;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 15'd0;
      mem_data_r   <= 3'd0;
      clr_cnt_r    <= 15'd0;
      clr_colour_r <= 3'd0;
      in_ready_r   <= 1'b1;
      idle_r       <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if ((state_r == ST_RUN) && clear_req) begin
        clr_colour_r <= clear_colour;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r    <= count_s;
      mem_we_r   <= mem_we_s;
      mem_addr_r <= mem_addr_s;
      mem_data_r <= mem_data_s;
      clr_cnt_r  <= clr_cnt_s;
      in_ready_r <= in_ready_s;
      idle_r     <= idle_s;
    end
  end

  // FIFO storage: packed {address, colour}; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {enq_addr_s, colour};
    end
  end

`ifdef PLOT_SINK_CLIP_COUNT_EN
  logic [15:0] clip_cnt_r;

  // Saturating count of commands discarded for being off-grid.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_cnt_r <= 16'd0;
    end else if (plot && !in_range_s && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end else begin
      clip_cnt_r <= clip_cnt_r;
    end
  end

  assign clip_count = clip_cnt_r;
`endif

  assign in_ready = in_ready_r;
  assign mem_we   = mem_we_r;
  assign mem_addr = mem_addr_r;
  assign mem_data = mem_data_r;
  assign idle     = idle_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: table of single plots plus hand-written
// sequences for backpressure, full-screen clear and reset during a clear.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x, y;
  logic [2:0]  colour;
  logic        plot;
  logic        in_ready;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready;
  logic        idle;
  logic        overflow;
`ifdef PLOT_SINK_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [17:0] wq[$];

  plot_sink #(.DEPTH(4), .WIDTH(160), .HEIGHT(120)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .in_ready(in_ready), .clear_req(clear_req), .clear_colour(clear_colour),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .idle(idle), .overflow(overflow)
`ifdef PLOT_SINK_CLIP_COUNT_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  // Record every completed framebuffer write as {addr, data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) wq.push_back({mem_addr, mem_data});
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        exp_we;
    logic [14:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wq.delete();
  endtask

  initial begin
    logic rdy [5];
    int   n_writes;
    int   errs;

    vecs[0] = '{x: 8'd72,  y: 8'd110, c: 3'd7, exp_we: 1'b1, exp_addr: 15'd17672};
    vecs[1] = '{x: 8'd0,   y: 8'd0,   c: 3'd1, exp_we: 1'b1, exp_addr: 15'd0};
    vecs[2] = '{x: 8'd159, y: 8'd119, c: 3'd5, exp_we: 1'b1, exp_addr: 15'd19199};
    vecs[3] = '{x: 8'd10,  y: 8'd1,   c: 3'd3, exp_we: 1'b1, exp_addr: 15'd170};
    vecs[4] = '{x: 8'd160, y: 8'd0,   c: 3'd2, exp_we: 1'b0, exp_addr: 15'd0};
    vecs[5] = '{x: 8'd0,   y: 8'd120, c: 3'd4, exp_we: 1'b0, exp_addr: 15'd0};
    vecs[6] = '{x: 8'd255, y: 8'd255, c: 3'd6, exp_we: 1'b0, exp_addr: 15'd0};

    x = 8'd0; y = 8'd0; colour = 3'd0; plot = 1'b0;
    clear_req = 1'b0; clear_colour = 3'd0; mem_ready = 1'b1;
    #1;
    do_reset();

    // Reset state.
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_idle",     32'(idle),     32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Table: one plot each, write expected two cycles after acceptance.
    n_writes = 0;
    for (int i = 0; i < 7; i++) begin
      x = vecs[i].x; y = vecs[i].y; colour = vecs[i].c; plot = 1'b1;
      tick();
      plot = 1'b0;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        n_writes++;
        chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_data", i), 32'(mem_data), 32'(vecs[i].c));
      end
      tick();
      chk($sformatf("vec%0d_we_off", i), 32'(mem_we), 32'd0);
      chk($sformatf("vec%0d_idle", i), 32'(idle), 32'd1);
    end
    chk("table_write_count", 32'(wq.size()), 32'(n_writes));
    chk("table_overflow", 32'(overflow), 32'd0);
`ifdef PLOT_SINK_CLIP_COUNT_EN
    chk("table_clip_count", 32'(clip_count), 32'd3);
`endif

    // Backpressure: one write stalled in the output register, then a burst of 5.
    do_reset();
    mem_ready = 1'b0;
    x = 8'd1; y = 8'd0; colour = 3'd6; plot = 1'b1;
    tick();
    plot = 1'b0;
    tick();
    chk("bp_stalled_we", 32'(mem_we), 32'd1);
    for (int k = 0; k < 5; k++) begin
      rdy[k] = in_ready;
      x = 8'(2 * k); y = 8'd1; colour = 3'(k + 1); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    for (int k = 0; k < 5; k++) chk($sformatf("bp_ready%0d", k), 32'(rdy[k]), (k < 4) ? 32'd1 : 32'd0);
    chk("bp_overflow", 32'(overflow), 32'd1);
    repeat (3) tick();
    chk("bp_hold_we",   32'(mem_we),   32'd1);
    chk("bp_hold_addr", 32'(mem_addr), 32'd1);
    chk("bp_hold_data", 32'(mem_data), 32'd6);
    chk("bp_no_write",  32'(wq.size()), 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && wq.size() < 5; i++) tick();
    repeat (3) tick();
    chk("bp_write_count", 32'(wq.size()), 32'd5);
    if (wq.size() == 5) begin
      chk("bp_w0", 32'(wq[0]), 32'({15'd1, 3'd6}));
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp_w%0d", k + 1), 32'(wq[k + 1]), 32'({15'(160 + 2 * k), 3'(k + 1)}));
    end
    chk("bp_overflow_sticky", 32'(overflow), 32'd1);
    chk("bp_idle", 32'(idle), 32'd1);

    // Clear: three plots drain first, then the whole screen in colour 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      x = 8'(5 + k); y = 8'd5; colour = 3'(k + 1); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    clear_req = 1'b1; clear_colour = 3'd0;
    tick();
    clear_req = 1'b0; clear_colour = 3'd7;
    repeat (30) tick();
    chk("clr_busy_idle", 32'(idle), 32'd0);
    x = 8'd3; y = 8'd3; colour = 3'd7; plot = 1'b1;
    tick();
    plot = 1'b0;
    chk("clr_plot_overflow", 32'(overflow), 32'd1);
    chk("clr_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20000 && !idle; i++) tick();
    chk("clr_idle_after", 32'(idle), 32'd1);
    chk("clr_in_ready_after", 32'(in_ready), 32'd1);
    chk("clr_write_count", 32'(wq.size()), 32'd19203);
    if (wq.size() == 19203) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("clr_plot%0d", k), 32'(wq[k]), 32'({15'(805 + k), 3'(k + 1)}));
      errs = 0;
      for (int a = 0; a < 19200; a++)
        if (wq[a + 3] !== {15'(a), 3'd0}) errs++;
      chk("clr_sweep_errors", 32'(errs), 32'd0);
    end

    // Reset partway through a clear.
    do_reset();
    clear_req = 1'b1; clear_colour = 3'd5;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 6000 && mem_addr != 15'd5000; i++) tick();
    chk("rc_reached_5000", 32'(mem_addr), 32'd5000);
    chk("rc_clear_data", 32'(mem_data), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rc_mem_we",   32'(mem_we),   32'd0);
    chk("rc_idle",     32'(idle),     32'd1);
    chk("rc_in_ready", 32'(in_ready), 32'd1);
    wq.delete();
    repeat (5) tick();
    chk("rc_no_writes", 32'(wq.size()), 32'd0);
    chk("rc_stays_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
